// File: rtl/spi_ram_burst_pkg.sv
// Shared types and helpers for the burst-capable SPI slave RAM.
// The optional parity feature is controlled by the SPI_RAM_PARITY_EN macro.
package spi_ram_burst_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  localparam int DEF_MEM_WIDTH = 8;
  localparam int DEF_MEM_DEPTH = 256;

  // Next index in a ring of `depth` entries.
  function automatic int unsigned wrap_inc(input int unsigned x, input int unsigned depth);
    return (x == depth - 32'd1) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI slave front end and spi_ram_burst.
// The parity_err signal exists only when SPI_RAM_PARITY_EN is defined.
interface spi_ram_burst_if #(
  parameter int MEM_WIDTH = 8,
  parameter int ADDR_SIZE = 8
);
  logic                 rx_valid;
  logic [MEM_WIDTH+1:0] din;
  logic [MEM_WIDTH-1:0] dout;
  logic                 tx_valid;
  logic                 seq_err;
  logic [ADDR_SIZE-1:0] addr_wr;
  logic [ADDR_SIZE-1:0] addr_rd;
`ifdef SPI_RAM_PARITY_EN
  logic                 parity_err;

  modport master (output rx_valid, din,
                  input  dout, tx_valid, seq_err, addr_wr, addr_rd, parity_err);
  modport slave  (input  rx_valid, din,
                  output dout, tx_valid, seq_err, addr_wr, addr_rd, parity_err);
`else
  modport master (output rx_valid, din,
                  input  dout, tx_valid, seq_err, addr_wr, addr_rd);
  modport slave  (input  rx_valid, din,
                  output dout, tx_valid, seq_err, addr_wr, addr_rd);
`endif
endinterface

// File: rtl/spi_ram_burst_ptr.sv
// Wrap-around RAM pointer: saturating load of an address, or advance by one
// with wrap at MEM_DEPTH-1. Load has priority over increment.
module spi_ram_burst_ptr
  import spi_ram_burst_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 inc,
  input  logic [ADDR_SIZE-1:0] load_val,
  output logic [ADDR_SIZE-1:0] ptr
);

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(MEM_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= (load_val > LAST_IDX) ? LAST_IDX : load_val;
    end else if (inc) begin
      ptr <= ADDR_SIZE'(wrap_inc(32'(ptr), 32'(MEM_DEPTH)));
    end
  end

endmodule

// File: rtl/spi_ram_burst.sv
// Single-port RAM behind an SPI slave: tagged address/data commands with
// auto-incrementing burst pointers. Optional word parity via SPI_RAM_PARITY_EN.
module spi_ram_burst
  import spi_ram_burst_pkg::*;
#(
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH),
  parameter int AUTO_INC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  spi_ram_burst_if.slave bus
);

`ifdef SPI_RAM_PARITY_EN
  localparam int STORE_W = MEM_WIDTH + 1;
`else
  localparam int STORE_W = MEM_WIDTH;
`endif
  localparam logic AUTO_INC_EN = (AUTO_INC != 0);

  // Stored word; in parity builds the top bit is the even-parity bit.
  function automatic logic [STORE_W-1:0] pack_word(input logic [MEM_WIDTH-1:0] d);
`ifdef SPI_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

`ifdef SPI_RAM_PARITY_EN
  function automatic logic parity_bad(input logic [STORE_W-1:0] w);
    return ^w;
  endfunction
`endif

  spi_cmd_e             cmd;
  logic [MEM_WIDTH-1:0] payload;
  logic [ADDR_SIZE-1:0] pay_addr;
  logic                 cmd_ok;
  logic                 wr_addr_ld;
  logic                 wr_data_en;
  logic                 rd_addr_ld;
  logic                 rd_go;
  logic                 rd_bad;
  logic                 rd_armed;
  logic [STORE_W-1:0]   rd_word;

  assign cmd      = spi_cmd_e'(bus.din[MEM_WIDTH+1:MEM_WIDTH]);
  assign payload  = bus.din[MEM_WIDTH-1:0];
  assign pay_addr = ADDR_SIZE'(payload);

  // Reset suppresses any command presented in the same cycle.
  assign cmd_ok     = bus.rx_valid && !rst;
  assign wr_addr_ld = cmd_ok && (cmd == CMD_WR_ADDR);
  assign wr_data_en = cmd_ok && (cmd == CMD_WR_DATA);
  assign rd_addr_ld = cmd_ok && (cmd == CMD_RD_ADDR);
  assign rd_go      = cmd_ok && (cmd == CMD_RD_DATA) && rd_armed;
  assign rd_bad     = cmd_ok && (cmd == CMD_RD_DATA) && !rd_armed;

  spi_ram_burst_ptr #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_addr_ld),
    .inc      (wr_data_en && AUTO_INC_EN),
    .load_val (pay_addr),
    .ptr      (bus.addr_wr)
  );

  spi_ram_burst_ptr #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_addr_ld),
    .inc      (rd_go && AUTO_INC_EN),
    .load_val (pay_addr),
    .ptr      (bus.addr_rd)
  );

  logic [STORE_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_data_en) begin
      mem[bus.addr_wr] <= pack_word(payload);
    end
  end

  assign rd_word = mem[bus.addr_rd];

  // ---- stage p1: registered read response and sequence error ----
  logic [MEM_WIDTH-1:0] dout_p1;
  logic                 vld_p1;
  logic                 seq_err_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1    <= '0;
      vld_p1     <= 1'b0;
      seq_err_p1 <= 1'b0;
      rd_armed   <= 1'b0;
    end else begin
      vld_p1     <= rd_go;
      seq_err_p1 <= rd_bad;
      if (rd_addr_ld) rd_armed <= 1'b1;
      if (rd_go)      dout_p1  <= rd_word[MEM_WIDTH-1:0];
    end
  end

  assign bus.dout     = dout_p1;
  assign bus.tx_valid = vld_p1;
  assign bus.seq_err  = seq_err_p1;

`ifdef SPI_RAM_PARITY_EN
  logic perr_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_p1 <= 1'b0;
    end else begin
      perr_p1 <= rd_go && parity_bad(rd_word);
    end
  end

  assign bus.parity_err = perr_p1;
`endif

endmodule
